// File: rtl/cp0_exc_sequencer.sv
// rtl/cp0_exc_sequencer.sv - exception/ERET sequencer and single-write-port arbiter for CP0
module cp0_exc_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtc0_we_i,
    input  logic [4:0]  mtc0_waddr_i,
    input  logic [31:0] mtc0_data_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_data_o,
    output logic        cause_upd_o,
    output logic        cause_bd_o,
    output logic [4:0]  cause_exccode_o,
    output logic        flush_o,
    output logic        stall_req_o,
    output logic        new_pc_valid_o,
    output logic [31:0] new_pc_o
);
    typedef enum logic [2:0] {IDLE, WR_EPC, WR_CAUSE, WR_STATUS, REDIRECT} state_t;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    state_t      state, state_next;
    logic [4:0]  code_q;
    logic        bd_q;
    logic        eret_q;
    logic [31:0] pc_q, status_q, epc_q, new_pc_q;
    logic        int_pend, take_exc, take_eret, accept;
    logic        unused_cause_bits;

    assign unused_cause_bits = ^{cause_i[30:16], cause_i[7:0]};

    assign int_pend  = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    assign take_exc  = mem_valid_i & (int_pend | exc_valid_i);
    assign take_eret = mem_valid_i & ~take_exc & eret_i;
    assign accept    = take_exc | take_eret;

    assign cause_bd_o      = bd_q;
    assign cause_exccode_o = code_q;
    assign new_pc_o        = new_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code_q   <= '0;
            bd_q     <= 1'b0;
            eret_q   <= 1'b0;
            pc_q     <= '0;
            status_q <= '0;
            epc_q    <= '0;
            new_pc_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                code_q   <= (take_exc && !int_pend) ? exc_code_i : 5'd0;
                // With EXL already set the existing BD must survive the Cause update.
                bd_q     <= status_i[1] ? cause_i[31] : mem_in_delayslot_i;
                eret_q   <= take_eret;
                pc_q     <= mem_pc_i;
                status_q <= status_i;
                epc_q    <= epc_i;
            end
            if (state == WR_STATUS)
                new_pc_q <= eret_q ? epc_q : EXC_VECTOR;
        end
    end

    always_comb begin
        state_next     = state;
        cp0_we_o       = 1'b0;
        cp0_waddr_o    = '0;
        cp0_data_o     = '0;
        cause_upd_o    = 1'b0;
        flush_o        = 1'b0;
        stall_req_o    = 1'b1;
        new_pc_valid_o = 1'b0;
        case (state)
            IDLE: begin
                stall_req_o = 1'b0;
                if (accept) begin
                    flush_o = 1'b1;
                    if (take_eret)        state_next = WR_STATUS;
                    else if (status_i[1]) state_next = WR_CAUSE;
                    else                  state_next = WR_EPC;
                end else begin
                    cp0_we_o    = mtc0_we_i;
                    cp0_waddr_o = mtc0_waddr_i;
                    cp0_data_o  = mtc0_data_i;
                end
            end
            WR_EPC: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = ADDR_EPC;
                cp0_data_o  = bd_q ? pc_q - 32'd4 : pc_q;
                state_next  = WR_CAUSE;
            end
            WR_CAUSE: begin
                cause_upd_o = 1'b1;
                state_next  = WR_STATUS;
            end
            WR_STATUS: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = ADDR_STATUS;
                cp0_data_o  = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
                state_next  = REDIRECT;
            end
            REDIRECT: begin
                new_pc_valid_o = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// tb/tb_cp0_exc_sequencer.sv - self-checking bench for cp0_exc_sequencer
module tb_cp0_exc_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        mtc0_we_i;
    logic [4:0]  mtc0_waddr_i;
    logic [31:0] mtc0_data_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic [31:0] status_i, cause_i, epc_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        cause_upd_o, cause_bd_o;
    logic [4:0]  cause_exccode_o;
    logic        flush_o, stall_req_o, new_pc_valid_o;
    logic [31:0] new_pc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_exc_sequencer dut (
        .clk(clk), .rst(rst),
        .mtc0_we_i(mtc0_we_i), .mtc0_waddr_i(mtc0_waddr_i), .mtc0_data_i(mtc0_data_i),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .eret_i(eret_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_data_o(cp0_data_o),
        .cause_upd_o(cause_upd_o), .cause_bd_o(cause_bd_o), .cause_exccode_o(cause_exccode_o),
        .flush_o(flush_o), .stall_req_o(stall_req_o),
        .new_pc_valid_o(new_pc_valid_o), .new_pc_o(new_pc_o)
    );

    // Expected behaviour of one cycle, as seen on the outputs.
    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        upd;
        logic        bd;
        logic [4:0]  code;
        logic        flush;
        logic        stall;
        logic        npv;
        logic [31:0] npc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_npc;

    task automatic clear_inputs();
        mtc0_we_i = 0; mtc0_waddr_i = 0; mtc0_data_i = 0;
        mem_valid_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0;
        exc_valid_i = 0; exc_code_i = 0; eret_i = 0;
        status_i = 0; cause_i = 0; epc_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_event(input logic v, input logic exc, input logic [4:0] code,
                             input logic eret, input logic [31:0] pc, input logic bd,
                             input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
        mem_valid_i = v; exc_valid_i = exc; exc_code_i = code; eret_i = eret;
        mem_pc_i = pc; mem_in_delayslot_i = bd; status_i = st; cause_i = ca; epc_i = ep;
    endtask

    // Reference: the cycle-by-cycle trace an event produces, derived from the architectural rules.
    task automatic model_event(input logic v, input logic exc, input logic [4:0] code,
                               input logic eret, input logic [31:0] pc, input logic bd,
                               input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                               input logic mwe, input logic [4:0] maddr, input logic [31:0] mdata);
        exp_t e;
        bit   ip, is_exc, is_eret, exl;
        ip      = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h0);
        is_exc  = v && (ip || exc);
        is_eret = v && !is_exc && eret;
        exl     = st[1];
        e = '{we:0, addr:0, data:0, upd:0, bd:0, code:0, flush:0, stall:0, npv:0, npc:0};
        if (!is_exc && !is_eret) begin
            e.we = mwe; e.addr = maddr; e.data = mdata;
            exp_q.push_back(e);
            return;
        end
        e.flush = 1;
        exp_q.push_back(e);
        e.flush = 0; e.stall = 1;
        if (is_exc) begin
            if (!exl) begin
                e.we = 1; e.addr = 14; e.data = bd ? pc - 32'd4 : pc;
                exp_q.push_back(e);
                e.we = 0;
            end
            e.upd = 1; e.bd = exl ? ca[31] : bd; e.code = ip ? 5'd0 : code;
            exp_q.push_back(e);
            e.upd = 0;
            e.we = 1; e.addr = 12; e.data = st | 32'h2;
            exp_q.push_back(e);
            e.we = 0; e.npv = 1; e.npc = 32'h20;
            exp_q.push_back(e);
        end else begin
            e.we = 1; e.addr = 12; e.data = st & ~32'h2;
            exp_q.push_back(e);
            e.we = 0; e.npv = 1; e.npc = ep;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        checks++;
        if ({cp0_we_o, cause_upd_o, flush_o, stall_req_o, new_pc_valid_o} !== 5'b0 || new_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b npc=%h want ctl=00000 npc=0",
                     {cp0_we_o, cause_upd_o, flush_o, stall_req_o, new_pc_valid_o}, new_pc_o);
        end
        last_npc = 32'h0;
    endtask

    task automatic test_passthrough();
        tick();
        mtc0_we_i = 1; mtc0_waddr_i = 5'd11; mtc0_data_i = 32'h100;
        #1;
        checks++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o} !== {1'b1, 5'd11, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL passthrough got we=%b a=%0d d=%h fl=%b want 1 11 00000100 0",
                     cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o);
        end
        // Exception without a valid instruction in MEM must not be taken
        set_event(0, 1, 5'd8, 1, 32'h40, 0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (flush_o !== 1'b0 || cp0_we_o !== 1'b1) begin
            errors++;
            $display("FAIL bubble_ignored got fl=%b we=%b want 0 1", flush_o, cp0_we_o);
        end
        clear_inputs();
    endtask

    task automatic test_syscall();
        tick();
        set_event(1, 1, 5'd8, 0, 32'h40, 0, 32'h1000_0000, 32'h0, 32'h0);
        mtc0_we_i = 1; mtc0_waddr_i = 5'd9;
        #1;
        checks++;
        if ({flush_o, stall_req_o, cp0_we_o} !== 3'b100) begin
            errors++;
            $display("FAIL syscall_T got fl/st/we=%b want 100", {flush_o, stall_req_o, cp0_we_o});
        end
        tick(); clear_inputs(); mtc0_we_i = 1; #1;
        checks++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o, stall_req_o, flush_o} !== {1'b1, 5'd14, 32'h40, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL syscall_epc got we=%b a=%0d d=%h st=%b fl=%b want 1 14 00000040 1 0",
                     cp0_we_o, cp0_waddr_o, cp0_data_o, stall_req_o, flush_o);
        end
        tick(); #1;
        checks++;
        if ({cause_upd_o, cause_exccode_o, cause_bd_o, cp0_we_o} !== {1'b1, 5'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL syscall_cause got upd=%b code=%0d bd=%b we=%b want 1 8 0 0",
                     cause_upd_o, cause_exccode_o, cause_bd_o, cp0_we_o);
        end
        tick(); #1;
        checks++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd12, 32'h1000_0002}) begin
            errors++;
            $display("FAIL syscall_status got we=%b a=%0d d=%h want 1 12 10000002", cp0_we_o, cp0_waddr_o, cp0_data_o);
        end
        tick(); #1;
        checks++;
        if ({new_pc_valid_o, new_pc_o, stall_req_o} !== {1'b1, 32'h20, 1'b1}) begin
            errors++;
            $display("FAIL syscall_redirect got v=%b pc=%h st=%b want 1 00000020 1", new_pc_valid_o, new_pc_o, stall_req_o);
        end
        tick(); mtc0_we_i = 0; #1;
        checks++;
        if ({new_pc_valid_o, stall_req_o, new_pc_o} !== {1'b0, 1'b0, 32'h20}) begin
            errors++;
            $display("FAIL syscall_idle got v=%b st=%b pc=%h want 0 0 00000020", new_pc_valid_o, stall_req_o, new_pc_o);
        end
        last_npc = 32'h20;
    endtask

    task automatic test_delay_slot();
        tick();
        set_event(1, 1, 5'd10, 0, 32'h104, 1, 32'h0000_0002, 32'h0, 32'h0);
        #1;
        tick(); clear_inputs(); #1;
        checks++;
        if ({cp0_we_o, cause_upd_o, cause_bd_o, cause_exccode_o} !== {1'b0, 1'b1, 1'b0, 5'd10}) begin
            errors++;
            $display("FAIL exl1_cause got we=%b upd=%b bd=%b code=%0d want 0 1 0 10",
                     cp0_we_o, cause_upd_o, cause_bd_o, cause_exccode_o);
        end
        tick(); tick(); #1;
        checks++;
        if ({new_pc_valid_o, new_pc_o} !== {1'b1, 32'h20}) begin
            errors++;
            $display("FAIL exl1_redirect_T3 got v=%b pc=%h want 1 00000020", new_pc_valid_o, new_pc_o);
        end
        tick();
        set_event(1, 1, 5'd10, 0, 32'h104, 1, 32'h0, 32'h0, 32'h0);
        #1;
        tick(); clear_inputs(); #1;
        checks++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd14, 32'h100}) begin
            errors++;
            $display("FAIL bd_epc got we=%b a=%0d d=%h want 1 14 00000100", cp0_we_o, cp0_waddr_o, cp0_data_o);
        end
        tick(); #1;
        checks++;
        if ({cause_upd_o, cause_bd_o} !== 2'b11) begin
            errors++;
            $display("FAIL bd_cause got upd=%b bd=%b want 1 1", cause_upd_o, cause_bd_o);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_interrupt();
        tick();
        set_event(1, 1, 5'd8, 0, 32'h300, 0, 32'h0000_0401, 32'h0000_0400, 32'h0);
        mtc0_we_i = 1; mtc0_waddr_i = 5'd12; mtc0_data_i = 32'hdead_beef;
        #1;
        checks++;
        if ({flush_o, cp0_we_o} !== 2'b10) begin
            errors++;
            $display("FAIL irq_T got fl=%b we=%b want 1 0", flush_o, cp0_we_o);
        end
        tick(); clear_inputs(); #1;
        checks++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd14, 32'h300}) begin
            errors++;
            $display("FAIL irq_epc got we=%b a=%0d d=%h want 1 14 00000300", cp0_we_o, cp0_waddr_o, cp0_data_o);
        end
        tick(); #1;
        checks++;
        if ({cause_upd_o, cause_exccode_o} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL irq_code got upd=%b code=%0d want 1 0", cause_upd_o, cause_exccode_o);
        end
        tick(); #1;
        checks++;
        if (cp0_data_o !== 32'h0000_0403) begin
            errors++;
            $display("FAIL irq_status got %h want 00000403", cp0_data_o);
        end
        tick();
    endtask

    task automatic test_eret();
        tick();
        set_event(1, 0, 5'd0, 1, 32'h80, 0, 32'h0000_0403, 32'h0, 32'h200);
        #1;
        checks++;
        if ({flush_o, stall_req_o, cp0_we_o} !== 3'b100) begin
            errors++;
            $display("FAIL eret_T got fl/st/we=%b want 100", {flush_o, stall_req_o, cp0_we_o});
        end
        tick(); clear_inputs(); #1;
        checks++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o, stall_req_o} !== {1'b1, 5'd12, 32'h0000_0401, 1'b1}) begin
            errors++;
            $display("FAIL eret_status got we=%b a=%0d d=%h st=%b want 1 12 00000401 1",
                     cp0_we_o, cp0_waddr_o, cp0_data_o, stall_req_o);
        end
        tick(); #1;
        checks++;
        if ({new_pc_valid_o, new_pc_o, stall_req_o} !== {1'b1, 32'h200, 1'b1}) begin
            errors++;
            $display("FAIL eret_redirect got v=%b pc=%h st=%b want 1 00000200 1", new_pc_valid_o, new_pc_o, stall_req_o);
        end
        tick(); #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL eret_stall_end got %b want 0", stall_req_o);
        end
        last_npc = 32'h200;
    endtask

    task automatic test_reset_mid();
        tick();
        set_event(1, 1, 5'd8, 0, 32'h40, 0, 32'h0, 32'h0, 32'h0);
        #1;
        tick(); clear_inputs(); #1;
        tick(); #1;
        rst = 1;
        tick(); rst = 0; #1;
        checks++;
        if ({cp0_we_o, cause_upd_o, flush_o, stall_req_o, new_pc_valid_o} !== 5'b0 || new_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got ctl=%b npc=%h want 00000 0",
                     {cp0_we_o, cause_upd_o, flush_o, stall_req_o, new_pc_valid_o}, new_pc_o);
        end
        tick(); #1;
        checks++;
        if ({cp0_we_o, stall_req_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_status got we=%b st=%b want 0 0", cp0_we_o, stall_req_o);
        end
        last_npc = 32'h0;
        set_event(1, 1, 5'd4, 0, 32'h500, 0, 32'h0, 32'h0, 32'h0);
        #1;
        tick(); clear_inputs(); #1;
        checks++;
        if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd14, 32'h500}) begin
            errors++;
            $display("FAIL after_reset_epc got we=%b a=%0d d=%h want 1 14 00000500", cp0_we_o, cp0_waddr_o, cp0_data_o);
        end
        tick(); tick(); tick(); #1;
        checks++;
        if ({new_pc_valid_o, new_pc_o} !== {1'b1, 32'h20}) begin
            errors++;
            $display("FAIL after_reset_redirect got v=%b pc=%h want 1 00000020", new_pc_valid_o, new_pc_o);
        end
        last_npc = 32'h20;
    endtask

    task automatic test_random();
        exp_t        e;
        logic        v, exc, eret, bd, mwe;
        logic [4:0]  code, maddr;
        logic [31:0] pc, st, ca, ep, mdata;
        int          cyc;
        tick();
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            exc = ($urandom_range(0, 2) == 0);
            eret = ($urandom_range(0, 3) == 0);
            bd = $urandom_range(0, 1);
            code = 5'($urandom);
            pc = $urandom & 32'hffff_fffc;
            st = $urandom & 32'h0000_ff03;
            ca = $urandom & 32'h8000_ff00;
            ep = $urandom;
            mwe = $urandom_range(0, 1);
            maddr = 5'($urandom);
            mdata = $urandom;
            exp_q.delete();
            model_event(v, exc, code, eret, pc, bd, st, ca, ep, mwe, maddr, mdata);
            cyc = 0;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (cyc == 0) begin
                    set_event(v, exc, code, eret, pc, bd, st, ca, ep);
                    mtc0_we_i = mwe; mtc0_waddr_i = maddr; mtc0_data_i = mdata;
                end else begin
                    set_event($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1),
                              $urandom, $urandom_range(0, 1), $urandom, $urandom, $urandom);
                    mtc0_we_i = $urandom_range(0, 1); mtc0_waddr_i = 5'($urandom); mtc0_data_i = $urandom;
                end
                #1;
                checks++;
                if ({cp0_we_o, cause_upd_o, flush_o, stall_req_o, new_pc_valid_o} !== {e.we, e.upd, e.flush, e.stall, e.npv}) begin
                    errors++;
                    $display("FAIL rand_ctl ev=%0d cyc=%0d got we/upd/fl/st/npv=%b want %b", n, cyc,
                             {cp0_we_o, cause_upd_o, flush_o, stall_req_o, new_pc_valid_o},
                             {e.we, e.upd, e.flush, e.stall, e.npv});
                end
                if (e.we) begin
                    checks++;
                    if ({cp0_waddr_o, cp0_data_o} !== {e.addr, e.data}) begin
                        errors++;
                        $display("FAIL rand_write ev=%0d cyc=%0d got a=%0d d=%h want a=%0d d=%h",
                                 n, cyc, cp0_waddr_o, cp0_data_o, e.addr, e.data);
                    end
                end
                if (e.upd) begin
                    checks++;
                    if ({cause_bd_o, cause_exccode_o} !== {e.bd, e.code}) begin
                        errors++;
                        $display("FAIL rand_cause ev=%0d got bd=%b code=%0d want bd=%b code=%0d",
                                 n, cause_bd_o, cause_exccode_o, e.bd, e.code);
                    end
                end
                if (e.npv) last_npc = e.npc;
                checks++;
                if (new_pc_o !== last_npc) begin
                    errors++;
                    $display("FAIL rand_new_pc ev=%0d cyc=%0d got %h want %h", n, cyc, new_pc_o, last_npc);
                end
                tick();
                cyc++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_syscall();
        test_delay_slot();
        test_interrupt();
        test_eret();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
